// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter and clear sequencer for the single-port matrix memory.
// Two clients share one read/write port; a clear sweep zeroes every entry.
module matrix_mem_arbiter #(
    parameter int DW = 8,
    parameter int m  = 8,
    parameter int n  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [m+n-1:0]    addr0,
    input  logic [m+n-1:0]    addr1,
    input  logic [2*DW-1:0]   wdata0,
    input  logic [2*DW-1:0]   wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [2*DW-1:0]   rdata,
    output logic              err,
    output logic              ramEN,
    output logic              writeEN,
    output logic              readEN,
    output logic [m+n-1:0]    memAddr,
    output logic [2*DW-1:0]   memDataIn,
    input  logic [2*DW-1:0]   memDataOut,
    output logic              dbg_state
);

    localparam int AW    = m + n;
    localparam int DEPTH = m * n;
    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          err_q, err_d;

    logic          pick0, pick1;
    logic          in_range0, in_range1;

    assign in_range0 = ({1'b0, addr0} < DEPTH_X);
    assign in_range1 = ({1'b0, addr1} < DEPTH_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err_q     <= err_d;
        end
    end

    // Handshake: a client holds reqN and its payload until gntN is seen high in the
    // same cycle; that cycle consumes the request. Nothing is queued here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err_d     = 1'b0;
        pick0     = 1'b0;
        pick1     = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ramEN     = 1'b0;
        writeEN   = 1'b0;
        readEN    = 1'b0;
        memAddr   = '0;
        memDataIn = '0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    // On a tie the client not served last wins; last_q=1 favours client 0.
                    pick0 = req0 && (!req1 || last_q);
                    pick1 = req1 && !pick0;
                    if (pick0) begin
                        gnt0   = 1'b1;
                        last_d = 1'b0;
                        if (in_range0) begin
                            ramEN   = 1'b1;
                            memAddr = addr0;
                            if (we0) begin
                                writeEN   = 1'b1;
                                memDataIn = wdata0;
                            end else begin
                                readEN    = 1'b1;
                                rvalid0_d = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (pick1) begin
                        gnt1   = 1'b1;
                        last_d = 1'b1;
                        if (in_range1) begin
                            ramEN   = 1'b1;
                            memAddr = addr1;
                            if (we1) begin
                                writeEN   = 1'b1;
                                memDataIn = wdata1;
                            end else begin
                                readEN    = 1'b1;
                                rvalid1_d = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                ramEN   = 1'b1;
                writeEN = 1'b1;
                memAddr = cnt_q;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Reset must silence the memory port at once, even mid-sweep.
        if (!rst_n) begin
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            ramEN     = 1'b0;
            writeEN   = 1'b0;
            readEN    = 1'b0;
            memAddr   = '0;
            memDataIn = '0;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign err       = err_q;
    assign rdata     = memDataOut;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Directed bench for matrix_mem_arbiter with a registered-read memory model.
module tb_matrix_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int DEPTH = 64;

  logic clk, rst_n, clr, busy;
  logic req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [2*DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, err;
  logic [2*DW-1:0] rdata;
  logic ramEN, writeEN, readEN;
  logic [AW-1:0] memAddr;
  logic [2*DW-1:0] memDataIn, memDataOut;
  logic dbg_state;

  int checks = 0;
  int errors = 0;
  logic load_mem;
  logic [2*DW-1:0] mem [DEPTH];

  matrix_mem_arbiter #(.DW(DW), .m(8), .n(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .ramEN(ramEN), .writeEN(writeEN), .readEN(readEN),
    .memAddr(memAddr), .memDataIn(memDataIn), .memDataOut(memDataOut),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: synchronous write, registered read
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 1) ? 16'h0011 : (i == 2) ? 16'h0022 : 16'h1000 + 16'(i);
    end else if (ramEN) begin
      if (writeEN) mem[memAddr[5:0]] <= memDataIn;
      if (readEN) memDataOut <= mem[memAddr[5:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; clr = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    load_mem = 1;
    req0 = 1; req1 = 1; addr0 = 16'd1; addr1 = 16'd2;
    tick(); tick();
    load_mem = 0;
    sample();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_ramEN", ramEN, 0);
    chk("rst_writeEN", writeEN, 0);
    chk("rst_readEN", readEN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_err", err, 0);
    chk("rst_memAddr", memAddr, 0);

    // dual continuous reads: first tie goes to client 0
    tick(); rst_n = 1;
    sample();
    chk("dual1_gnt", {gnt0, gnt1}, 2'b10);
    chk("dual1_ram", {ramEN, readEN, writeEN}, 3'b110);
    chk("dual1_addr", memAddr, 1);
    chk("dual1_rv", {rvalid0, rvalid1}, 2'b00);
    tick(); sample();
    chk("dual2_gnt", {gnt0, gnt1}, 2'b01);
    chk("dual2_addr", memAddr, 2);
    chk("dual2_rv", {rvalid0, rvalid1}, 2'b10);
    chk("dual2_rdata", rdata, 16'h0011);
    tick(); sample();
    chk("dual3_gnt", {gnt0, gnt1}, 2'b10);
    chk("dual3_rv", {rvalid0, rvalid1}, 2'b01);
    chk("dual3_rdata", rdata, 16'h0022);
    tick(); sample();
    chk("dual4_gnt", {gnt0, gnt1}, 2'b01);
    chk("dual4_rv", {rvalid0, rvalid1}, 2'b10);
    chk("dual4_rdata", rdata, 16'h0011);
    tick(); req0 = 0; req1 = 0;
    sample();
    chk("dual5_gnt", {gnt0, gnt1}, 2'b00);
    chk("dual5_ramEN", ramEN, 0);
    chk("dual5_rv", {rvalid0, rvalid1}, 2'b01);
    chk("dual5_rdata", rdata, 16'h0022);

    // client 0 write then read back
    tick(); req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 16'hABCD;
    sample();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_ctl", {ramEN, writeEN, readEN}, 3'b110);
    chk("wr_addr", memAddr, 5);
    chk("wr_data", memDataIn, 16'hABCD);
    chk("wr_rv1", rvalid1, 0);
    tick(); we0 = 0;
    sample();
    chk("rd_gnt0", gnt0, 1);
    chk("rd_ctl", {ramEN, writeEN, readEN}, 3'b101);
    tick(); req0 = 0;
    sample();
    chk("rd_rv", {rvalid0, rvalid1}, 2'b10);
    chk("rd_rdata", rdata, 16'hABCD);

    // out-of-range write by client 1
    tick(); req1 = 1; we1 = 1; addr1 = 16'd64; wdata1 = 16'hDEAD;
    sample();
    chk("oor_gnt1", gnt1, 1);
    chk("oor_ctl", {ramEN, writeEN, readEN}, 3'b000);
    chk("oor_err0", err, 0);
    tick(); req1 = 0; we1 = 0; req0 = 1; addr0 = 16'd0;
    sample();
    chk("oor_err1", err, 1);
    chk("oor_gnt0", gnt0, 1);
    tick(); req0 = 0;
    sample();
    chk("oor_err_end", err, 0);
    chk("oor_rv", rvalid0, 1);
    chk("oor_addr0", rdata, 16'h1000);

    // full clear sweep with client 0 waiting
    tick(); clr = 1; req0 = 1; we0 = 0; addr0 = 16'd5;
    sample();
    chk("clr_req_gnt0", gnt0, 0);
    chk("clr_req_ram", ramEN, 0);
    chk("clr_req_busy", busy, 0);
    for (int k = 0; k < DEPTH; k++) begin
      tick(); clr = 0;
      sample();
      chk("sweep_busy", busy, 1);
      chk("sweep_gnt0", gnt0, 0);
      chk("sweep_ctl", {ramEN, writeEN, readEN}, 3'b110);
      chk("sweep_addr", memAddr, 32'(k));
      chk("sweep_data", memDataIn, 0);
    end
    tick(); sample();
    chk("post_busy", busy, 0);
    chk("post_gnt0", gnt0, 1);
    chk("post_addr", memAddr, 5);
    tick(); req0 = 0;
    sample();
    chk("post_rv", rvalid0, 1);
    chk("post_rdata", rdata, 0);

    // write addr 20, then abort a sweep at cycle 10
    tick(); req1 = 1; we1 = 1; addr1 = 16'd20; wdata1 = 16'h5A5A;
    sample();
    chk("w20_gnt1", gnt1, 1);
    tick(); req1 = 0; we1 = 0; clr = 1;
    sample();
    chk("clr2_ram", ramEN, 0);
    for (int k = 0; k < 10; k++) begin
      tick(); clr = 0;
      sample();
      chk("sweep2_addr", memAddr, 32'(k));
    end
    tick(); rst_n = 0; req0 = 1; req1 = 1;
    sample();
    chk("abort_busy", busy, 0);
    chk("abort_ctl", {ramEN, writeEN, readEN}, 3'b000);
    chk("abort_gnt", {gnt0, gnt1}, 2'b00);
    chk("abort_addr", memAddr, 0);
    tick(); rst_n = 1; req0 = 0; req1 = 1; addr1 = 16'd20;
    sample();
    chk("r20_gnt1", gnt1, 1);
    chk("r20_busy", busy, 0);
    tick(); req1 = 0; req0 = 1; addr0 = 16'd9;
    sample();
    chk("r20_rv", rvalid1, 1);
    chk("r20_rdata", rdata, 16'h5A5A);
    chk("r9_gnt0", gnt0, 1);
    tick(); req0 = 0; rst_n = 0;
    sample();
    chk("rv_suppressed", rvalid0, 0);
    tick(); rst_n = 1;
    sample();
    chk("rv_after_rst", {rvalid0, rvalid1, err}, 3'b000);

    // pointer restored by reset: tie goes to client 0 again
    tick(); req0 = 1; req1 = 1; addr0 = 16'd9; addr1 = 16'd20;
    sample();
    chk("tie_gnt", {gnt0, gnt1}, 2'b10);
    tick(); req0 = 0; req1 = 0;
    sample();
    chk("r9_rv", rvalid0, 1);
    chk("r9_rdata", rdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
